// File: rtl/irrigation_zone_sequencer.sv
// Multi-zone irrigation sequencer: one valve open at a time, timed dwell,
// break-before-make gap between zones, latched 3-bit mode code for display.
module irrigation_zone_sequencer #(
  parameter int ZONES       = 4,
  parameter int ZONE_W      = 2,
  parameter int CNT_W       = 8,
  parameter int DWELL_TICKS = 10,
  parameter int GAP_TICKS   = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic              irrigation_on,
  input  logic              splinker_on,
  input  logic              dripper_on,
  input  logic [ZONES-1:0]  zone_enable,
  output logic [ZONES-1:0]  valve,
  output logic [2:0]        mode_code,
  output logic [ZONE_W-1:0] active_zone,
  output logic              busy,
  output logic              fault,
  output logic              cycle_done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP,
    FAULT
  } state_t;

  localparam logic [ZONES-1:0] ONE   = ZONES'(1);
  localparam logic [CNT_W-1:0] DWELL = CNT_W'(DWELL_TICKS);
  localparam logic [CNT_W-1:0] GAPV  = CNT_W'(GAP_TICKS);

  state_t             state;
  logic [CNT_W-1:0]   counter;
  logic               first_found;
  logic [ZONE_W-1:0]  first_idx;
  logic               next_found;
  logic [ZONE_W-1:0]  next_idx;
  logic               both_modes;
  logic               one_mode;
  logic               gap_end;

  assign both_modes = splinker_on & dripper_on;
  assign one_mode   = splinker_on ^ dripper_on;
  assign gap_end    = (counter == '0) ||
                      (tick && counter == CNT_W'(1));

  // Descending scans so the last hit is the lowest qualifying index
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = ZONES - 1; i >= 0; i--) begin
      if (zone_enable[i]) begin
        first_found = 1'b1;
        first_idx   = ZONE_W'(i);
      end
      if (zone_enable[i] && i > int'(active_zone)) begin
        next_found = 1'b1;
        next_idx   = ZONE_W'(i);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      counter     <= '0;
      valve       <= '0;
      mode_code   <= 3'b000;
      active_zone <= '0;
      busy        <= 1'b0;
      fault       <= 1'b0;
      cycle_done  <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (irrigation_on && both_modes) begin
            state     <= FAULT;
            fault     <= 1'b1;
            mode_code <= 3'b111;
          end else if (irrigation_on && one_mode && first_found) begin
            state       <= RUN;
            mode_code   <= splinker_on ? 3'b101 : 3'b100;
            active_zone <= first_idx;
            valve       <= ONE << first_idx;
            counter     <= DWELL;
            busy        <= 1'b1;
          end
        end
        RUN: begin
          if (!irrigation_on) begin
            state     <= IDLE;
            valve     <= '0;
            busy      <= 1'b0;
            mode_code <= 3'b000;
            counter   <= '0;
          end else if (both_modes) begin
            state     <= FAULT;
            valve     <= '0;
            busy      <= 1'b0;
            fault     <= 1'b1;
            mode_code <= 3'b111;
            counter   <= '0;
          end else if (tick) begin
            if (counter == CNT_W'(1)) begin
              state   <= GAP;
              valve   <= '0;
              counter <= GAPV;
            end else begin
              counter <= counter - CNT_W'(1);
            end
          end
        end
        GAP: begin
          if (!irrigation_on) begin
            state     <= IDLE;
            busy      <= 1'b0;
            mode_code <= 3'b000;
            counter   <= '0;
          end else if (both_modes) begin
            state     <= FAULT;
            busy      <= 1'b0;
            fault     <= 1'b1;
            mode_code <= 3'b111;
            counter   <= '0;
          end else if (gap_end) begin
            if (next_found) begin
              state       <= RUN;
              active_zone <= next_idx;
              valve       <= ONE << next_idx;
              counter     <= DWELL;
            end else begin
              state      <= IDLE;
              busy       <= 1'b0;
              mode_code  <= 3'b000;
              cycle_done <= 1'b1;
              counter    <= '0;
            end
          end else if (tick) begin
            counter <= counter - CNT_W'(1);
          end
        end
        FAULT: begin
          if (!irrigation_on) begin
            state     <= IDLE;
            fault     <= 1'b0;
            mode_code <= 3'b000;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irrigation_zone_sequencer.sv
// Directed bench: expected per-clock outputs queued per step, popped and
// compared after each edge. Second instance exercises a zero-length gap.
module tb_irrigation_zone_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick;
  logic       irrigation_on;
  logic       splinker_on;
  logic       dripper_on;
  logic [3:0] zone_enable;

  logic [3:0] valve_a, valve_b;
  logic [2:0] mode_a, mode_b;
  logic [1:0] zone_a, zone_b;
  logic       busy_a, busy_b;
  logic       fault_a, fault_b;
  logic       done_a, done_b;

  typedef struct packed {
    logic [3:0] v;
    logic [2:0] m;
    logic       b;
    logic       d;
    logic       f;
  } obs_t;

  obs_t q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clock = ~clock;

  irrigation_zone_sequencer #(
    .ZONES(4), .ZONE_W(2), .CNT_W(8),
    .DWELL_TICKS(3), .GAP_TICKS(1)
  ) dut_a (
    .clock(clock), .reset(reset), .tick(tick),
    .irrigation_on(irrigation_on),
    .splinker_on(splinker_on),
    .dripper_on(dripper_on),
    .zone_enable(zone_enable),
    .valve(valve_a), .mode_code(mode_a),
    .active_zone(zone_a), .busy(busy_a),
    .fault(fault_a), .cycle_done(done_a)
  );

  irrigation_zone_sequencer #(
    .ZONES(4), .ZONE_W(2), .CNT_W(8),
    .DWELL_TICKS(3), .GAP_TICKS(0)
  ) dut_b (
    .clock(clock), .reset(reset), .tick(tick),
    .irrigation_on(irrigation_on),
    .splinker_on(splinker_on),
    .dripper_on(dripper_on),
    .zone_enable(zone_enable),
    .valve(valve_b), .mode_code(mode_b),
    .active_zone(zone_b), .busy(busy_b),
    .fault(fault_b), .cycle_done(done_b)
  );

  function automatic obs_t mk(input logic [3:0] v, input logic [2:0] m,
                              input logic b, input logic d, input logic f);
    obs_t e;
    e.v = v; e.m = m; e.b = b; e.d = d; e.f = f;
    return e;
  endfunction

  task automatic push(input obs_t e, input int n);
    repeat (n) q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input bit use_b, input int div);
    obs_t e;
    obs_t o;
    int k;
    k = 0;
    while (q.size() > 0) begin
      tick = ((k % div) == 0);
      @(posedge clock); #1;
      e = q.pop_front();
      if (use_b) o = {valve_b, mode_b, busy_b, done_b, fault_b};
      else       o = {valve_a, mode_a, busy_a, done_a, fault_a};
      check($sformatf("%s[%0d]", tag, k), 32'(o), 32'(e));
      k++;
    end
    tick = 1'b0;
  endtask

  initial begin
    obs_t idle;
    idle = mk(4'b0000, 3'b000, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; tick = 1'b0; irrigation_on = 1'b0;
    splinker_on = 1'b0; dripper_on = 1'b0; zone_enable = 4'b0000;

    // reset values
    push(idle, 2); run("reset_a", 1'b0, 1);
    push(idle, 1); run("reset_b", 1'b1, 1);
    check("reset_zone_a", 32'(zone_a), 32'd0);
    check("reset_zone_b", 32'(zone_b), 32'd0);
    reset = 1'b0;
    push(idle, 1); run("idle", 1'b0, 1);

    // normal splinker sequence, zone 2 skipped
    irrigation_on = 1'b1; splinker_on = 1'b1; zone_enable = 4'b1011;
    push(mk(4'b0001, 3'b101, 1, 0, 0), 3);
    push(mk(4'b0000, 3'b101, 1, 0, 0), 1);
    push(mk(4'b0010, 3'b101, 1, 0, 0), 3);
    push(mk(4'b0000, 3'b101, 1, 0, 0), 1);
    push(mk(4'b1000, 3'b101, 1, 0, 0), 3);
    push(mk(4'b0000, 3'b101, 1, 0, 0), 1);
    push(mk(4'b0000, 3'b000, 0, 1, 0), 1);
    run("normal", 1'b0, 1);
    irrigation_on = 1'b0;
    push(idle, 2); run("normal_end", 1'b0, 1);
    check("normal_last_zone", 32'(zone_a), 32'd3);

    // dripper, single zone, tick every 4th clock
    irrigation_on = 1'b1; splinker_on = 1'b0; dripper_on = 1'b1;
    zone_enable = 4'b0100;
    push(mk(4'b0100, 3'b100, 1, 0, 0), 12);
    push(mk(4'b0000, 3'b100, 1, 0, 0), 4);
    push(mk(4'b0000, 3'b000, 0, 1, 0), 1);
    run("dripper", 1'b0, 4);
    irrigation_on = 1'b0;
    push(idle, 1); run("dripper_end", 1'b0, 1);
    check("dripper_zone", 32'(zone_a), 32'd2);

    // fault at start, sticky until irrigation_on drops
    irrigation_on = 1'b1; splinker_on = 1'b1; dripper_on = 1'b1;
    zone_enable = 4'b0001;
    push(mk(4'b0000, 3'b111, 0, 0, 1), 1); run("fault_start", 1'b0, 1);
    splinker_on = 1'b0; dripper_on = 1'b0;
    push(mk(4'b0000, 3'b111, 0, 0, 1), 2); run("fault_sticky", 1'b0, 1);
    irrigation_on = 1'b0;
    push(idle, 1); run("fault_exit", 1'b0, 1);

    // fault raised mid-RUN
    irrigation_on = 1'b1; splinker_on = 1'b1;
    push(mk(4'b0001, 3'b101, 1, 0, 0), 2); run("mid_run", 1'b0, 1);
    dripper_on = 1'b1;
    push(mk(4'b0000, 3'b111, 0, 0, 1), 1); run("mid_fault", 1'b0, 1);
    dripper_on = 1'b0;
    push(mk(4'b0000, 3'b111, 0, 0, 1), 1); run("mid_sticky", 1'b0, 1);
    irrigation_on = 1'b0;
    push(idle, 1); run("mid_exit", 1'b0, 1);

    // irrigation_on dropped during zone 1 RUN
    irrigation_on = 1'b1; zone_enable = 4'b0011;
    push(mk(4'b0001, 3'b101, 1, 0, 0), 3);
    push(mk(4'b0000, 3'b101, 1, 0, 0), 1);
    push(mk(4'b0010, 3'b101, 1, 0, 0), 1);
    run("abort_run", 1'b0, 1);
    irrigation_on = 1'b0;
    push(idle, 3); run("abort_idle", 1'b0, 1);

    // reset mid-GAP after zone 1
    irrigation_on = 1'b1; zone_enable = 4'b0111;
    push(mk(4'b0001, 3'b101, 1, 0, 0), 3);
    push(mk(4'b0000, 3'b101, 1, 0, 0), 1);
    push(mk(4'b0010, 3'b101, 1, 0, 0), 3);
    push(mk(4'b0000, 3'b101, 1, 0, 0), 1);
    run("pre_reset", 1'b0, 1);
    check("pre_reset_zone", 32'(zone_a), 32'd1);
    reset = 1'b1; irrigation_on = 1'b0;
    push(idle, 1); run("gap_reset", 1'b0, 1);
    check("gap_reset_zone", 32'(zone_a), 32'd0);
    reset = 1'b0;

    // all zones disabled mid-RUN: dwell completes, cycle ends
    irrigation_on = 1'b1; zone_enable = 4'b0011;
    push(mk(4'b0001, 3'b101, 1, 0, 0), 1); run("dis_start", 1'b0, 1);
    zone_enable = 4'b0000;
    push(mk(4'b0001, 3'b101, 1, 0, 0), 2);
    push(mk(4'b0000, 3'b101, 1, 0, 0), 1);
    push(mk(4'b0000, 3'b000, 0, 1, 0), 1);
    push(idle, 1);
    run("dis_finish", 1'b0, 1);
    irrigation_on = 1'b0;
    push(idle, 2); run("dis_idle", 1'b0, 1);

    // zero-length gap still closes valves for one clock
    irrigation_on = 1'b1; zone_enable = 4'b0011;
    push(mk(4'b0001, 3'b101, 1, 0, 0), 3);
    push(mk(4'b0000, 3'b101, 1, 0, 0), 1);
    push(mk(4'b0010, 3'b101, 1, 0, 0), 3);
    push(mk(4'b0000, 3'b101, 1, 0, 0), 1);
    push(mk(4'b0000, 3'b000, 0, 1, 0), 1);
    run("gap0", 1'b1, 1);
    irrigation_on = 1'b0;
    push(idle, 1); run("gap0_end", 1'b1, 1);
    check("gap0_zone", 32'(zone_b), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
